// File: rtl/maxpool_2x2.sv
// Streaming 2x2 / stride-2 signed max-pool over six feature-map channels.
// Pixels arrive in raster order. A half-width line buffer holds the pairwise
// row maxima of each even row. The matching odd row folds them in, so no
// full frame is ever stored.
module maxpool_2x2 #(
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic [DATA_W-1:0] in_4,
  input  logic [DATA_W-1:0] in_5,
  output logic              pool_valid,
  output logic [DATA_W-1:0] pool_0,
  output logic [DATA_W-1:0] pool_1,
  output logic [DATA_W-1:0] pool_2,
  output logic [DATA_W-1:0] pool_3,
  output logic [DATA_W-1:0] pool_4,
  output logic [DATA_W-1:0] pool_5,
  output logic [((IMG_H/2) > 1 ? $clog2(IMG_H/2) : 1)-1:0] pool_row,
  output logic [((IMG_W/2) > 1 ? $clog2(IMG_W/2) : 1)-1:0] pool_col,
  output logic              frame_done
);

  localparam int NCH = 6;
  localparam int PRW = (IMG_H/2) > 1 ? $clog2(IMG_H/2) : 1;
  localparam int PCW = (IMG_W/2) > 1 ? $clog2(IMG_W/2) : 1;
  localparam int CCW = $clog2(IMG_W);
  localparam int RCW = $clog2(IMG_H);
  localparam int LBD = IMG_W/2;
  localparam logic [CCW-1:0] COL_LAST = CCW'(IMG_W-1);
  localparam logic [RCW-1:0] ROW_LAST = RCW'(IMG_H-1);

  // Signed maximum; on a tie either operand is equally correct.
  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  logic [DATA_W-1:0] in_s   [NCH];
  logic [DATA_W-1:0] hold_q [NCH];
  logic [DATA_W-1:0] lbuf_q [NCH][LBD];
  logic [DATA_W-1:0] pool_q [NCH];

  logic [CCW-1:0] col_q, col_d;
  logic [RCW-1:0] row_q, row_d;
  logic           pool_valid_q, pool_valid_d;
  logic           frame_done_q, frame_done_d;
  logic [PRW-1:0] pool_row_q, pool_row_d;
  logic [PCW-1:0] pool_col_q, pool_col_d;

  logic           accept_s;
  logic           win_end_s;
  logic [PCW-1:0] lidx_s;
  logic [PRW-1:0] prow_s;

  assign in_s[0] = in_0;
  assign in_s[1] = in_1;
  assign in_s[2] = in_2;
  assign in_s[3] = in_3;
  assign in_s[4] = in_4;
  assign in_s[5] = in_5;

  // A sample is taken only when neither reset nor clear claims the cycle.
  assign accept_s  = in_valid & ~clear & ~reset;
  assign win_end_s = row_q[0] & col_q[0];
  assign lidx_s    = PCW'(col_q >> 1);
  assign prow_s    = PRW'(row_q >> 1);

  // Next-state for raster counters and output control.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pool_valid_d = 1'b0;
    frame_done_d = 1'b0;
    pool_row_d   = pool_row_q;
    pool_col_d   = pool_col_q;
    if (clear) begin
      col_d      = '0;
      row_d      = '0;
      pool_row_d = '0;
      pool_col_d = '0;
    end else if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + RCW'(1);
        end
      end else begin
        col_d = col_q + CCW'(1);
      end
      if (win_end_s) begin
        pool_valid_d = 1'b1;
        pool_row_d   = prow_s;
        pool_col_d   = lidx_s;
        frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end else begin
        pool_valid_d = 1'b0;
      end
    end else begin
      pool_valid_d = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      pool_row_q   <= '0;
      pool_col_q   <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pool_valid_q <= pool_valid_d;
      frame_done_q <= frame_done_d;
      pool_row_q   <= pool_row_d;
      pool_col_q   <= pool_col_d;
    end
  end

  // Partial maxima: even rows fill the line buffer, odd rows fold it into hold.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int c = 0; c < NCH; c++) begin
        case ({row_q[0], col_q[0]})
          2'b00:   hold_q[c] <= in_s[c];
          2'b01:   lbuf_q[c][lidx_s] <= smax(hold_q[c], in_s[c]);
          2'b10:   hold_q[c] <= smax(in_s[c], lbuf_q[c][lidx_s]);
          default: hold_q[c] <= hold_q[c];
        endcase
      end
    end
  end

  // Pooled result register; clear leaves the last values in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) pool_q[c] <= '0;
    end else if (accept_s && win_end_s) begin
      for (int c = 0; c < NCH; c++) pool_q[c] <= smax(hold_q[c], in_s[c]);
    end
  end

  assign pool_valid = pool_valid_q;
  assign frame_done = frame_done_q;
  assign pool_row   = pool_row_q;
  assign pool_col   = pool_col_q;
  assign pool_0     = pool_q[0];
  assign pool_1     = pool_q[1];
  assign pool_2     = pool_q[2];
  assign pool_3     = pool_q[3];
  assign pool_4     = pool_q[4];
  assign pool_5     = pool_q[5];

endmodule

// File: tb/tb_maxpool_2x2.sv
// Scoreboard bench for maxpool_2x2: a frame-memory reference model pushes
// the expected pooled pixel when a window's bottom-right pixel is issued;
// a monitor pops and compares whenever pool_valid is seen.
module tb_maxpool_2x2;

  localparam int W = 24;
  localparam int H = 24;

  typedef logic [5:0][15:0] pix_t;
  typedef struct packed {
    pix_t       d;
    logic [3:0] r;
    logic [3:0] c;
    logic       done;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0, in_4 = '0, in_5 = '0;
  logic        pool_valid;
  logic [15:0] pool_0, pool_1, pool_2, pool_3, pool_4, pool_5;
  logic [3:0]  pool_row, pool_col;
  logic        frame_done;

  maxpool_2x2 #(.IMG_W(W), .IMG_H(H), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3), .in_4(in_4), .in_5(in_5),
    .pool_valid(pool_valid),
    .pool_0(pool_0), .pool_1(pool_1), .pool_2(pool_2),
    .pool_3(pool_3), .pool_4(pool_4), .pool_5(pool_5),
    .pool_row(pool_row), .pool_col(pool_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  pix_t frame_mem [H][W];
  int   mrow = 0, mcol = 0;
  int   n_done_exp = 0, n_done_seen = 0;
  pix_t last_d = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Reference: remember the whole frame, pool each window from its four pixels.
  task automatic model_accept(input pix_t p);
    exp_t e;
    frame_mem[mrow][mcol] = p;
    if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
      for (int ch = 0; ch < 6; ch++)
        e.d[ch] = smax(smax(frame_mem[mrow-1][mcol-1][ch], frame_mem[mrow-1][mcol][ch]),
                       smax(frame_mem[mrow][mcol-1][ch], p[ch]));
      e.r    = 4'(mrow / 2);
      e.c    = 4'(mcol / 2);
      e.done = (mrow == H-1) && (mcol == W-1);
      if (e.done) n_done_exp++;
      q.push_back(e);
    end
    mcol++;
    if (mcol == W) begin
      mcol = 0;
      mrow = (mrow + 1) % H;
    end
  endtask

  function automatic pix_t rand_pix();
    pix_t p;
    for (int ch = 0; ch < 6; ch++) p[ch] = 16'($urandom);
    return p;
  endfunction

  task automatic set_in(input pix_t p);
    in_0 = p[0]; in_1 = p[1]; in_2 = p[2]; in_3 = p[3]; in_4 = p[4]; in_5 = p[5];
  endtask

  // One valid input cycle; with clr set the sample is discarded by the DUT.
  task automatic send(input pix_t p, input bit clr);
    @(negedge clk);
    in_valid = 1'b1;
    clear    = clr;
    set_in(p);
    if (clr) begin
      mrow = 0;
      mcol = 0;
    end else begin
      model_accept(p);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b0;
    end
  endtask

  task automatic rand_frame(input int max_gap);
    for (int i = 0; i < W*H; i++) begin
      send(rand_pix(), 1'b0);
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
    end
  endtask

  // Two-cycle reset with a live input; checks reset values on the second cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    set_in(rand_pix());
    mrow = 0;
    mcol = 0;
    @(negedge clk);
    chk("rst_pool_valid", 128'(pool_valid), 128'(0));
    chk("rst_frame_done", 128'(frame_done), 128'(0));
    chk("rst_pool_data", 128'({pool_5, pool_4, pool_3, pool_2, pool_1, pool_0}), 128'(0));
    chk("rst_row_col", 128'({pool_row, pool_col}), 128'(0));
    reset = 1'b0;
    in_valid = 1'b0;
    last_d = '0;
  endtask

  // Monitor: every pool_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (pool_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 128'(1), 128'(0));
      end else begin
        e = q.pop_front();
        chk("pool_data", 128'({pool_5, pool_4, pool_3, pool_2, pool_1, pool_0}), 128'(e.d));
        chk("pool_row_col", 128'({pool_row, pool_col}), 128'({e.r, e.c}));
        chk("frame_done", 128'(frame_done), 128'(e.done));
        last_d = e.d;
      end
    end
    if (frame_done) begin
      n_done_seen++;
      if (!pool_valid) chk("done_without_valid", 128'(1), 128'(0));
    end
  end

  initial begin
    pix_t p;
    int   idx;

    // Reset values.
    repeat (2) @(negedge clk);
    do_reset();

    // Directed frame: ch0 = raster index, signed windows at (0,0) on ch2/ch4.
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        p = rand_pix();
        idx = r * W + c;
        p[0] = 16'(idx);
        if (r < 2 && c < 2) begin
          case (r * 2 + c)
            0:       begin p[2] = 16'hFFFD; p[4] = 16'h7FFF; end
            1:       begin p[2] = 16'hFFFF; p[4] = 16'h8000; end
            2:       begin p[2] = 16'hFFF8; p[4] = 16'h0000; end
            default: begin p[2] = 16'hFFFE; p[4] = 16'h0001; end
          endcase
        end
        send(p, 1'b0);
        if (r == 1 && c == 1) begin
          idle(1);
          chk("dir_valid", 128'(pool_valid), 128'(1));
          chk("dir_pool0", 128'(pool_0), 128'(16'd25));
          chk("dir_pool2_neg", 128'(pool_2), 128'(16'hFFFF));
          chk("dir_pool4_extreme", 128'(pool_4), 128'(16'h7FFF));
        end
      end
    end
    idle(2);

    // Random frame with 0..3 idle cycles between pixels.
    rand_frame(3);
    idle(2);

    // Abort after 30 pixels via reset, then a clean frame.
    for (int i = 0; i < 30; i++) send(rand_pix(), 1'b0);
    do_reset();
    chk("abort_no_pending", 128'(q.size()), 128'(0));
    rand_frame(0);
    idle(2);

    // Two back-to-back continuous frames.
    rand_frame(0);
    rand_frame(0);
    idle(2);

    // clear coincident with pixel (1,1): no output, values kept, restart at (0,0).
    for (int i = 0; i < W + 1; i++) send(rand_pix(), 1'b0);
    send(rand_pix(), 1'b1);
    idle(1);
    chk("clear_no_output", 128'(pool_valid), 128'(0));
    chk("clear_keeps_data", 128'({pool_5, pool_4, pool_3, pool_2, pool_1, pool_0}), 128'(last_d));
    chk("clear_row_col", 128'({pool_row, pool_col}), 128'(0));
    rand_frame(1);

    idle(6);
    chk("queue_drained", 128'(q.size()), 128'(0));
    chk("frame_done_count", 128'(n_done_seen), 128'(n_done_exp));
    chk("frame_done_total", 128'(n_done_exp), 128'(6));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
